// File: rtl/recirc_activation_ctrl_if.sv
// Word stream, enable and status bundle between the stream source and the activation controller.
interface recirc_activation_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic [WIDTH-1:0] data_input;
  logic             valid;
  logic             active;
  logic [1:0]       state;
  logic [3:0]       idle_count;
  logic             lock_lost;

  modport master (
    output enable, data_input, valid,
    input  active, state, idle_count, lock_lost
  );

  modport slave (
    input  enable, data_input, valid,
    output active, state, idle_count, lock_lost
  );
endinterface

// File: rtl/recirc_activation_ctrl.sv
// Link-activation controller: goes ACTIVE after LOCK_COUNT idle words, back to SEARCH after LOSS_COUNT valid gaps.
// All outputs registered; a decision on the sampled inputs is visible right after that edge.
module recirc_activation_ctrl #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] IDLE_WORD = 32'hBCBCBCBC,
  parameter int              LOCK_COUNT = 4,
  parameter int              LOSS_COUNT = 2
) (
  input  logic                        clk_2f,
  input  logic                        reset,
  recirc_activation_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    ACTIVE = 2'b10,
    BAD    = 2'b11
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

  state_t     r_state;
  logic       r_active;
  logic [3:0] r_idle_cnt;
  logic [3:0] r_loss_cnt;
  logic       r_lock_lost;

  logic [3:0] w_idle_inc;
  logic [3:0] w_loss_inc;
  logic       w_is_idle;

  assign w_idle_inc = r_idle_cnt + 4'd1;
  assign w_loss_inc = r_loss_cnt + 4'd1;
  assign w_is_idle  = (bus.data_input == IDLE_WORD);

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_active    <= 1'b0;
      r_idle_cnt  <= 4'd0;
      r_loss_cnt  <= 4'd0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      // Disable is a deliberate stop, so it pre-empts lock/loss and never pulses lock_lost.
      if (!bus.enable) begin
        r_state    <= IDLE;
        r_active   <= 1'b0;
        r_idle_cnt <= 4'd0;
        r_loss_cnt <= 4'd0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= SEARCH;
            r_active   <= 1'b0;
            r_idle_cnt <= 4'd0;
            r_loss_cnt <= 4'd0;
          end
          SEARCH: begin
            r_active <= 1'b0;
            if (bus.valid) begin
              if (!w_is_idle) begin
                r_idle_cnt <= 4'd0;
              end else if (w_idle_inc == LOCK_C) begin
                r_state    <= ACTIVE;
                r_active   <= 1'b1;
                r_idle_cnt <= 4'd0;
                r_loss_cnt <= 4'd0;
              end else begin
                r_idle_cnt <= w_idle_inc;
              end
            end
          end
          ACTIVE: begin
            r_active <= 1'b1;
            if (bus.valid) begin
              r_loss_cnt <= 4'd0;
            end else if (w_loss_inc == LOSS_C) begin
              r_state     <= SEARCH;
              r_active    <= 1'b0;
              r_lock_lost <= 1'b1;
              r_idle_cnt  <= 4'd0;
              r_loss_cnt  <= 4'd0;
            end else begin
              r_loss_cnt <= w_loss_inc;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_active   <= 1'b0;
            r_idle_cnt <= 4'd0;
            r_loss_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  assign bus.active     = r_active;
  assign bus.state      = r_state;
  assign bus.idle_count = r_idle_cnt;
  assign bus.lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_recirc_activation_ctrl.sv
// Scoreboard bench for recirc_activation_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_recirc_activation_ctrl;
  localparam logic [31:0] IDLE_W = 32'hBCBCBCBC;
  localparam int LOCK = 4;
  localparam int LOSS = 2;

  typedef struct {
    logic       active;
    logic [1:0] state;
    logic [3:0] idle_count;
    logic       lock_lost;
    string      tag;
  } exp_t;

  logic clk_2f = 1'b0;
  logic reset  = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  exp_t sb_q[$];
  string cur_tag = "init";

  // Reference model: link mode plus run / gap lengths in plain integers
  int  m_mode = 0;   // 0 idle, 1 hunting for idle run, 2 linked
  int  m_run  = 0;
  int  m_gap  = 0;
  bit  m_lost = 0;
  int  m_fwd  = 0;
  int  d_fwd  = 0;

  recirc_activation_ctrl_if #(.WIDTH(32)) bus ();

  recirc_activation_ctrl #(
    .WIDTH(32), .IDLE_WORD(IDLE_W), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)
  ) dut (
    .clk_2f(clk_2f),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2f = ~clk_2f;

  // Recirculator view: a valid word seen while active goes to demux_0, else to demux_1_probador
  always @(posedge clk_2f) begin
    if (reset && bus.valid && bus.active === 1'b1) d_fwd <= d_fwd + 1;
  end

  task automatic model_edge(input logic rst, input logic en, input logic v, input logic [31:0] d);
    if (rst && v && m_mode == 2) m_fwd++;
    m_lost = 0;
    if (!rst || !en) begin
      m_mode = 0; m_run = 0; m_gap = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (v) begin
        m_run = (d == IDLE_W) ? m_run + 1 : 0;
        if (m_run >= LOCK) begin m_mode = 2; m_run = 0; m_gap = 0; end
      end
    end else begin
      m_gap = v ? 0 : m_gap + 1;
      if (m_gap >= LOSS) begin m_mode = 1; m_lost = 1; m_gap = 0; m_run = 0; end
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic v, input logic [31:0] d);
    exp_t e;
    reset = rst; bus.enable = en; bus.valid = v; bus.data_input = d;
    @(posedge clk_2f);
    model_edge(rst, en, v, d);
    e.active = (m_mode == 2);
    e.state = 2'(m_mode);
    e.idle_count = 4'(m_run);
    e.lock_lost = m_lost;
    e.tag = cur_tag;
    sb_q.push_back(e);
    #1;
  endtask

  // Monitor: outputs are presented every cycle, compared away from the active edge
  always @(negedge clk_2f) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.active !== e.active || bus.state !== e.state ||
          bus.idle_count !== e.idle_count || bus.lock_lost !== e.lock_lost) begin
        n_bad++;
        $display("FAIL %s: got act=%b st=%b cnt=%0d lost=%b, want act=%b st=%b cnt=%0d lost=%b",
                 e.tag, bus.active, bus.state, bus.idle_count, bus.lock_lost,
                 e.active, e.state, e.idle_count, e.lock_lost);
      end
    end
  end

  initial begin
    bus.enable = 1'b0; bus.valid = 1'b0; bus.data_input = '0;

    cur_tag = "reset";
    repeat (3) step(1'b0, 1'($urandom), 1'($urandom), $urandom);

    cur_tag = "lock";
    step(1, 1, 0, 0);
    repeat (4) step(1, 1, 1, IDLE_W);

    cur_tag = "loss_short";
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h0);
    cur_tag = "loss";
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, IDLE_W);

    cur_tag = "broken_run";
    step(1, 1, 1, IDLE_W);
    step(1, 1, 1, IDLE_W);
    step(1, 1, 0, IDLE_W);
    step(1, 1, 1, 32'h12345678);
    repeat (4) step(1, 1, 1, IDLE_W);

    cur_tag = "disable";
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, IDLE_W);

    cur_tag = "reset_mid";
    step(1, 1, 1, IDLE_W);
    step(1, 1, 1, IDLE_W);
    step(1, 1, 1, IDLE_W);
    step(0, 1, 1, IDLE_W);
    step(1, 1, 1, IDLE_W);
    repeat (4) step(1, 1, 1, IDLE_W);

    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      logic r, en, v;
      logic [31:0] d;
      r  = ($urandom_range(99) >= 2);
      en = ($urandom_range(99) >= 3);
      v  = ($urandom_range(99) < 75);
      d  = ($urandom_range(99) < 70) ? IDLE_W : $urandom;
      step(r, en, v, d);
    end

    repeat (2) @(negedge clk_2f);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    n_cmp++;
    if (d_fwd != m_fwd) begin
      n_bad++;
      $display("FAIL demux0_words: got %0d, want %0d", d_fwd, m_fwd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
